// File: rtl/karpentium_pkg.sv
// Shared definitions for the Karpentium IV core: opcodes, FSM states, ALU selects.
package karpentium_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_IN  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_AND = 4'hB;
  localparam logic [3:0] OP_OR  = 4'hC;
  localparam logic [3:0] OP_XOR = 4'hD;
  localparam logic [3:0] OP_NOT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH, S_LOAD_IR, S_EXEC, S_MEM, S_IN_WAIT, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT
  } alu_sel_t;

  // Opcodes that read a memory operand and finish in the MEM state.
  function automatic logic is_alu_mem_op(input logic [3:0] op);
    return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

  function automatic alu_sel_t alu_sel_of(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      default: return ALU_PASS_B;
    endcase
  endfunction

endpackage

// File: rtl/karpentium_alu.sv
// Combinational ALU; carry is carry-out on ADD, no-borrow on SUB, zero otherwise.
module karpentium_alu
  import karpentium_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_sel_t          sel,
  output logic [DATA_W-1:0] y,
  output logic              carry
);

  logic [DATA_W:0] wide;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    wide  = '0;
    y     = b;
    carry = 1'b0;
    unique case (sel)
      ALU_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = wide[DATA_W];
      end
      ALU_SUB: begin
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[DATA_W-1:0];
        carry = ~wide[DATA_W];
      end
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_NOT:    y = ~a;
      ALU_PASS_B: y = b;
      default:    y = b;
    endcase
  end

endmodule

// File: rtl/karpentium_core_iv.sv
// Multicycle accumulator core: FSM-sequenced datapath with sync memory port,
// handshaked input, strobed output and a halt state.
module karpentium_core_iv
  import karpentium_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        ir_op;
  logic [ADDR_W-1:0] ir_operand;
  logic [DATA_W-1:0] acc;
  logic              z_flag;
  logic              c_flag;

  alu_sel_t          alu_sel;
  logic [DATA_W-1:0] alu_y;
  logic              alu_c;

  // EXEC only reaches the ALU for NOT; MEM uses the opcode's own operation.
  assign alu_sel = (state == S_EXEC) ? ALU_NOT : alu_sel_of(ir_op);

  karpentium_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (acc),
    .b     (mem_rdata),
    .sel   (alu_sel),
    .y     (alu_y),
    .carry (alu_c)
  );

  assign mem_addr  = (state == S_EXEC && (is_alu_mem_op(ir_op) || ir_op == OP_STA))
                     ? ir_operand : pc;
  assign mem_wdata = acc;
  assign mem_we    = (state == S_EXEC) && (ir_op == OP_STA) && !clr;
  assign in_ready  = (state == S_IN_WAIT) && in_valid && !clr;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    out_valid <= 1'b0;
    if (clr) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir_op      <= '0;
      ir_operand <= '0;
      acc        <= '0;
      z_flag     <= 1'b0;
      c_flag     <= 1'b0;
      out_data   <= '0;
      halted     <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: state <= S_LOAD_IR;
        S_LOAD_IR: begin
          ir_op      <= mem_rdata[DATA_W-1 -: 4];
          ir_operand <= mem_rdata[ADDR_W-1:0];
          pc         <= pc + 1'b1;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          case (ir_op)
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state <= S_MEM;
            OP_LDI: begin
              acc    <= DATA_W'(ir_operand);
              z_flag <= (ir_operand == '0);
              c_flag <= 1'b0;
            end
            OP_JMP: pc <= ir_operand;
            OP_JZ:  if (z_flag) pc <= ir_operand;
            OP_JC:  if (c_flag) pc <= ir_operand;
            OP_IN:  state <= S_IN_WAIT;
            OP_OUT: begin
              out_data  <= acc;
              out_valid <= 1'b1;
            end
            OP_NOT: begin
              acc    <= alu_y;
              z_flag <= (alu_y == '0);
              c_flag <= 1'b0;
            end
            OP_HLT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            default: ;  // NOP, and STA whose write strobe is combinational
          endcase
        end
        S_MEM: begin
          acc    <= alu_y;
          z_flag <= (alu_y == '0);
          c_flag <= alu_c;
          state  <= S_FETCH;
        end
        S_IN_WAIT: begin
          if (in_valid) begin
            acc    <= in_data;
            z_flag <= (in_data == '0);
            c_flag <= 1'b0;
            state  <= S_FETCH;
          end
        end
        S_HALT:  ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_karpentium_core_iv.sv
// Self-checking bench: directed scenarios plus random forward-jump programs
// compared against an instruction-level reference interpreter.
module tb_karpentium_core_iv;

  logic        clk = 1'b0;
  logic        clr, clr8;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata, in_data, out_data;
  logic        mem_we, in_valid, in_ready, out_valid, halted;
  logic [3:0]  mem_addr8;
  logic [7:0]  mem_wdata8, mem_rdata8, in_data8, out_data8;
  logic        mem_we8, in_valid8, in_ready8, out_valid8, halted8;

  always #5 clk = ~clk;

  karpentium_core_iv dut (
    .clk(clk), .clr(clr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .halted(halted)
  );

  karpentium_core_iv #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .clr(clr8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_we(mem_we8),
    .mem_rdata(mem_rdata8), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .halted(halted8)
  );

  logic [15:0] mem   [256];
  logic [15:0] m_mem [256];
  logic [7:0]  mem8  [16];

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_in = 1'b0;
  int n_ready = 0;

  logic [15:0] in_q[$], in_list[$];
  logic [15:0] obs_out[$], exp_out[$];
  logic [7:0]  obs_st_a[$], exp_st_a[$];
  logic [15:0] obs_st_d[$], exp_st_d[$];
  logic [7:0]  obs_out8[$], exp8[$];
  int          exp_in_cnt;

  logic [7:0]  s_addr;
  logic        s_we, s_in_ready, s_out_valid, s_halted;
  logic [15:0] s_out_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample mid-cycle, service both memories, update read data after the edge.
  task automatic step();
    logic [15:0] rd;
    logic [7:0]  rd8;
    if (rand_in) begin
      in_valid = (in_q.size() > 0) && ($urandom_range(0, 1) == 1);
      in_data  = in_valid ? in_q[0] : 16'($urandom);
    end
    @(negedge clk);
    s_addr = mem_addr; s_we = mem_we; s_in_ready = in_ready;
    s_out_valid = out_valid; s_out_data = out_data; s_halted = halted;
    if (mem_we) begin
      obs_st_a.push_back(mem_addr);
      obs_st_d.push_back(mem_wdata);
    end
    if (out_valid) obs_out.push_back(out_data);
    if (in_ready) begin
      n_ready++;
      if (rand_in && in_q.size() > 0) void'(in_q.pop_front());
    end
    rd = mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
    if (out_valid8) obs_out8.push_back(out_data8);
    rd8 = mem8[mem_addr8];
    if (mem_we8) mem8[mem_addr8] = mem_wdata8;
    @(posedge clk);
    #1;
    mem_rdata  = rd;
    mem_rdata8 = rd8;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
  endtask

  task automatic reset_core();
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    obs_out.delete(); obs_st_a.delete(); obs_st_d.delete();
    n_ready = 0;
  endtask

  task automatic run_prog(input int budget, input string tag);
    int n = 0;
    reset_core();
    while (!s_halted && n < budget) begin
      step();
      n++;
    end
    check({tag, " halt_reached"}, s_halted, 1);
  endtask

  task automatic compare_obs(input string tag);
    check({tag, " out_count"}, obs_out.size(), exp_out.size());
    foreach (exp_out[i])
      if (i < obs_out.size()) check($sformatf("%s out[%0d]", tag, i), obs_out[i], exp_out[i]);
    check({tag, " store_count"}, obs_st_a.size(), exp_st_a.size());
    foreach (exp_st_a[i])
      if (i < obs_st_a.size()) begin
        check($sformatf("%s st_addr[%0d]", tag, i), obs_st_a[i], exp_st_a[i]);
        check($sformatf("%s st_data[%0d]", tag, i), obs_st_d[i], exp_st_d[i]);
      end
  endtask

  // Instruction-level interpreter over m_mem, consuming in_list in order.
  task automatic model_run();
    logic [7:0]  pc = 8'h00;
    logic [15:0] acc = 16'h0000, ir, opv;
    logic [16:0] wide;
    logic        z = 1'b0, c = 1'b0;
    logic [7:0]  opd;
    int          k = 0;
    exp_out.delete(); exp_st_a.delete(); exp_st_d.delete();
    for (int n = 0; n < 200; n++) begin
      ir  = m_mem[pc];
      pc  = pc + 8'd1;
      opd = ir[7:0];
      opv = m_mem[opd];
      case (ir[15:12])
        4'h1: begin acc = opv; c = 1'b0; end
        4'h2: begin wide = {1'b0, acc} + {1'b0, opv}; acc = wide[15:0]; c = wide[16]; end
        4'h3: begin c = (acc >= opv); acc = acc - opv; end
        4'h4: begin m_mem[opd] = acc; exp_st_a.push_back(opd); exp_st_d.push_back(acc); end
        4'h5: begin acc = {8'h00, opd}; c = 1'b0; end
        4'h6: pc = opd;
        4'h7: if (z) pc = opd;
        4'h8: if (c) pc = opd;
        4'h9: begin acc = (k < in_list.size()) ? in_list[k] : 16'h0000; k++; c = 1'b0; end
        4'hA: exp_out.push_back(acc);
        4'hB: begin acc = acc & opv; c = 1'b0; end
        4'hC: begin acc = acc | opv; c = 1'b0; end
        4'hD: begin acc = acc ^ opv; c = 1'b0; end
        4'hE: begin acc = ~acc; c = 1'b0; end
        4'hF: begin exp_in_cnt = k; return; end
        default: ;
      endcase
      if (ir[15:12] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE}) z = (acc == 16'h0000);
    end
    exp_in_cnt = k;
  endtask

  initial begin
    int first_ready;
    logic [3:0] op;
    logic [7:0] opd;
    clr = 1'b1; clr8 = 1'b1;
    in_valid = 1'b0; in_data = '0; in_valid8 = 1'b0; in_data8 = '0;
    mem_rdata = '0; mem_rdata8 = '0;
    for (int a = 0; a < 16; a++) mem8[a] = 8'h00;

    // Reset values, OUT timing, PC advance and halt behaviour
    clear_mem();
    mem[0] = 16'h5005; mem[1] = 16'hA000; mem[2] = 16'hF000;
    reset_core();
    check("rst halted", halted, 0);
    check("rst out_data", out_data, 0);
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_we", mem_we, 0);
    for (int i = 0; i < 29; i++) begin
      step();
      if (i == 5) check("out_valid before c6", s_out_valid, 0);
      if (i == 6) begin
        check("out_valid c6", s_out_valid, 1);
        check("out_data c6", s_out_data, 16'h0005);
        check("pc after LDI/OUT", s_addr, 8'h02);
      end
      if (i == 7) check("out_valid single pulse", s_out_valid, 0);
      if (i == 8) check("not halted during HLT exec", s_halted, 0);
      if (i >= 9) begin
        check("halted held", s_halted, 1);
        check("halt mem_addr frozen", s_addr, 8'h03);
        check("halt no write", s_we, 0);
      end
    end

    // ADD carry into JC, JZ on zero, SUB with borrow
    clear_mem();
    mem[8'h00] = 16'h5001; mem[8'h01] = 16'h2010; mem[8'h02] = 16'h8020; mem[8'h03] = 16'hF000;
    mem[8'h10] = 16'hFFFF; mem[8'h11] = 16'h0005;
    mem[8'h20] = 16'hA000; mem[8'h21] = 16'h7023; mem[8'h22] = 16'hF000;
    mem[8'h23] = 16'h5003; mem[8'h24] = 16'h3011; mem[8'h25] = 16'hA000;
    mem[8'h26] = 16'h8028; mem[8'h27] = 16'hA000; mem[8'h28] = 16'hF000;
    run_prog(200, "arith");
    exp_out = '{16'h0000, 16'hFFFE, 16'hFFFE};
    exp_st_a.delete(); exp_st_d.delete();
    compare_obs("arith");

    // Store then reload through memory
    clear_mem();
    mem[0] = 16'h502A; mem[1] = 16'h4030; mem[2] = 16'h5000; mem[3] = 16'h1030;
    mem[4] = 16'hA000; mem[5] = 16'h7007; mem[6] = 16'hF000; mem[7] = 16'hA000;
    run_prog(200, "stld");
    exp_out = '{16'h002A};
    exp_st_a = '{8'h30}; exp_st_d = '{16'h002A};
    compare_obs("stld");
    check("stld mem[0x30]", mem[8'h30], 16'h002A);

    // IN handshake with in_valid low for 5 waiting cycles
    clear_mem();
    mem[0] = 16'h9000; mem[1] = 16'hA000; mem[2] = 16'hF000;
    in_valid = 1'b0; in_data = 16'h1234;
    reset_core();
    first_ready = -1;
    for (int i = 0; i < 40; i++) begin
      in_valid = (i >= 8);
      step();
      if (s_in_ready && first_ready < 0) first_ready = i;
    end
    in_valid = 1'b0;
    check("in_ready pulse count", n_ready, 1);
    check("in_ready cycle", first_ready, 8);
    exp_out = '{16'h1234};
    exp_st_a.delete(); exp_st_d.delete();
    compare_obs("in");

    // clr asserted during the STA execute cycle
    clear_mem();
    mem[0] = 16'h502A; mem[1] = 16'h4030; mem[8'h30] = 16'h5555;
    reset_core();
    for (int i = 0; i < 5; i++) step();
    clr = 1'b1;
    step();
    check("clr sta addr", s_addr, 8'h30);
    check("clr sta we gated", s_we, 0);
    step();
    check("clr sta no write", mem[8'h30], 16'h5555);
    check("clr pc reset", mem_addr, 8'h00);
    check("clr out_data reset", out_data, 0);
    mem[0] = 16'hA000; mem[1] = 16'hF000;
    run_prog(100, "clr_acc");
    exp_out = '{16'h0000};
    exp_st_a.delete(); exp_st_d.delete();
    compare_obs("clr_acc");

    // Random forward-jump programs against the interpreter
    for (int r = 0; r < 20; r++) begin
      clear_mem();
      for (int a = 0; a < 32; a++) begin
        op = 4'($urandom_range(0, 15));
        if (a == 31) op = 4'hF;
        else if (op == 4'hF) op = 4'($urandom_range(0, 14));
        opd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        if (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD}) opd = 8'($urandom_range(128, 255));
        else if (op inside {4'h6, 4'h7, 4'h8}) opd = 8'($urandom_range(a + 1, 31));
        mem[a] = {op, 4'($urandom_range(0, 15)), opd};
      end
      for (int a = 128; a < 256; a++)
        mem[a] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      in_q.delete();
      for (int i = 0; i < 40; i++)
        in_q.push_back(($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom));
      m_mem = mem;
      in_list = in_q;
      model_run();
      rand_in = 1'b1;
      run_prog(3000, $sformatf("rnd%0d", r));
      rand_in = 1'b0;
      in_valid = 1'b0;
      compare_obs($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d in_count", r), n_ready, exp_in_cnt);
    end

    // 8-bit data / 4-bit address build: zero-extension, carry, PC wrap
    mem8[0] = 8'h5F; mem8[1] = 8'hA0; mem8[2] = 8'h2E; mem8[3] = 8'h85; mem8[4] = 8'hF0;
    mem8[5] = 8'hA0; mem8[6] = 8'h6F; mem8[14] = 8'hF2; mem8[15] = 8'hA0;
    clr8 = 1'b1;
    step();
    step();
    clr8 = 1'b0;
    obs_out8.delete();
    for (int i = 0; i < 60; i++) step();
    exp8 = '{8'h0F, 8'h01, 8'h01, 8'h0F};
    check("p8 out_count_ge4", obs_out8.size() >= 4, 1);
    foreach (exp8[i])
      if (i < obs_out8.size()) check($sformatf("p8 out[%0d]", i), obs_out8[i], exp8[i]);
    check("p8 not halted", halted8, 0);
    check("p8 no in_ready", in_ready8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/karpentium_core_iv.md
Name: karpentium_core_iv

Overview:
- Parametrised multicycle accumulator processor core; successor to the fixed 16-bit/6-bit shared-bus Karpentium III.
- Replaces the separate PC/MAR/IR/MDR/controller tri-state bus with one FSM-sequenced datapath.
- Adds an external synchronous memory port, conditional jumps on Z/C flags, handshaked input, a valid-strobed output and a halt state.
- Sits at the system top, between program/data RAM and board I/O.

Parameters:
- DATA_W, 16, accumulator/memory/IO word width; must be ≥ ADDR_W+4.
- ADDR_W, 8, memory address width; PC and operand field width; memory depth 2^ADDR_W.

Ports:
- clk, input, 1, sole clock, rising edge.
- clr, input, 1, reset, synchronous, active-high.
- mem_addr, output, ADDR_W, memory address.
- mem_wdata, output, DATA_W, write data (= ACC).
- mem_we, output, 1, write enable, single-cycle.
- mem_rdata, input, DATA_W, read data, valid one cycle after mem_addr is presented.
- in_data, input, DATA_W, input port word.
- in_valid, input, 1, input word available.
- in_ready, output, 1, one-cycle pulse when in_data is consumed.
- out_data, output, DATA_W, output register.
- out_valid, output, 1, one-cycle pulse when out_data is updated.
- halted, output, 1, core stopped by HLT.

Behaviour:
- Clock and reset: one clock, clk. Reset clr is synchronous, active-high.
- Reset values: PC=0, ACC=0, IR=0, Z=0, C=0, out_data=0, out_valid=0, in_ready=0, halted=0, state=FETCH.
  - mem_we is gated low whenever clr=1.
  - Asserting clr mid-instruction abandons the instruction; no memory write occurs that cycle.
- Instruction format: opcode = IR[DATA_W-1:DATA_W-4]; operand = IR[ADDR_W-1:0]. Intermediate bits are ignored.
- FSM states: FETCH → LOAD_IR → EXEC → {MEM → FETCH | IN_WAIT → FETCH | FETCH | HALT}.
  - FETCH: mem_addr=PC.
  - LOAD_IR: IR<=mem_rdata; PC<=PC+1, wrapping mod 2^ADDR_W.
  - EXEC: decode and act, see opcodes below.
  - MEM: ACC<=alu(ACC, mem_rdata); Z and C updated.
  - HALT: halted=1; no memory access; exited only by clr.
- Opcodes (executed in EXEC):
  - 0 NOP.
  - 1 LDA, 2 ADD, 3 SUB, B AND, C OR, D XOR: mem_addr=operand, then go to MEM.
  - 4 STA: mem_addr=operand, mem_we=1, mem_wdata=ACC.
  - 5 LDI: ACC<=zero-extended operand.
  - 6 JMP: PC<=operand.
  - 7 JZ: PC<=operand if Z=1.
  - 8 JC: PC<=operand if C=1.
  - 9 IN: go to IN_WAIT.
  - A OUT: out_data<=ACC; out_valid=1 for the next cycle only.
  - E NOT: ACC<=~ACC.
  - F HLT: go to HALT.
- Latency: memory-operand ALU ops (LDA/ADD/SUB/AND/OR/XOR) take 4 cycles; all others take 3, except IN, which takes 3 plus wait cycles.
- Flags:
  - Z = (new ACC == 0), updated on every ACC write (LDA, LDI, ALU ops, NOT, IN).
  - C on ADD = carry out of DATA_W bits.
  - C on SUB = no-borrow (ACC ≥ operand, unsigned).
  - C is cleared by AND/OR/XOR/NOT/LDA/LDI/IN.
  - Jumps and STA leave both flags unchanged.
- Arithmetic: all ALU results wrap modulo 2^DATA_W.
- IN handshake:
  - In IN_WAIT, in_ready=0 while in_valid=0.
  - In the first cycle with in_valid=1: ACC<=in_data, in_ready=1 for that cycle, next state FETCH.
  - in_valid already high on arrival in IN_WAIT is consumed that same cycle.
- Wrap: PC at 2^ADDR_W-1 fetches, then continues at address 0.
- mem_addr is don't-care in states that do not access memory; it is driven to PC there for determinism.

Decomposition:
- Package karpentium_pkg holds:
  - opcode localparams (OP_NOP … OP_HLT);
  - FSM state encoding (S_FETCH, S_LOAD_IR, S_EXEC, S_MEM, S_IN_WAIT, S_HALT);
  - ALU select codes.
- One natural sub-module: karpentium_alu, combinational, DATA_W-parametrised, (a, b, sel) → (y, carry).
- The FSM, PC, IR, ACC, flags and I/O registers stay in the core.

Test Plan:
- Reset/fetch: hold clr 2 cycles, release; mem preloaded mem[0]=LDI 5, mem[1]=OUT → out_data=5 with out_valid pulse in cycle 6 after release; PC=2.
- Arithmetic and carry (DATA_W=16): mem[0x10]=0xFFFF; program LDI 1, ADD 0x10, JC 0x20 → ACC=0, Z=1, C=1, PC=0x20. SUB from 3 by 5 → ACC=0xFFFE, C=0.
- Store/load: LDI 0x2A, STA 0x30, LDI 0, LDA 0x30 → exactly one mem_we pulse, at addr 0x30 with wdata=0x2A; final ACC=0x2A, Z=0.
- IN handshake: execute IN with in_valid low for 5 cycles, then high with in_data=0x1234 → in_ready pulses once, in the cycle in_valid is first high; ACC=0x1234; no extra consumption.
- HLT and reset mid-op: HLT → halted=1, and no mem address/write change for 20 cycles. Separately, assert clr during an STA EXEC cycle → mem_we=0 that cycle; all registers return to reset values.
- Parameter sweep: DATA_W=8/ADDR_W=4 → PC wraps 15→0; LDI 0xF zero-extends to 0x0F; ADD overflow sets C.
